// File: rtl/simple_axis_fifo_pkg.sv
// Shared constants and stored-entry record for the upsizing AXI4-Stream FIFO.
package simple_axis_fifo_pkg;

  localparam int unsigned DATA_IN_W  = 16;
  localparam int unsigned DATA_OUT_W = 128;
  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned DIV        = DATA_OUT_W / DATA_IN_W;
  localparam int unsigned DEPTH      = 1 << ADDR_W;
  localparam int unsigned PTR_W      = ADDR_W + 1;

  typedef struct packed {
    logic [DATA_OUT_W-1:0] data;
    logic                  last;
  } entry_t;

endpackage

// File: rtl/simple_axis_fifo_packer.sv
// DIV-lane gearbox: packs narrow beats LSB-first into a wide word, zero-filling on tlast.
module simple_axis_fifo_packer #(
  parameter int unsigned DATA_IN_WIDTH  = 16,
  parameter int unsigned DATA_OUT_WIDTH = 128,
  parameter int unsigned DIV            = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      beat_en,
  input  logic [DATA_IN_WIDTH-1:0]  beat_data,
  input  logic                      beat_last,
  output logic                      word_en_c,
  output logic [DATA_OUT_WIDTH-1:0] word_data_c,
  output logic                      word_last_c
);

  localparam int unsigned LANE_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [LANE_W-1:0]         lane;
  logic [DATA_OUT_WIDTH-1:0] acc;
  logic                      flush_c;

  // Current beat merged into the partially filled word; lanes above it are still zero.
  always_comb begin
    flush_c     = beat_last || (lane == LANE_W'(DIV - 1));
    word_data_c = acc | (DATA_OUT_WIDTH'(beat_data) << (32'(lane) * DATA_IN_WIDTH));
    word_en_c   = beat_en && flush_c;
    word_last_c = beat_last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane <= '0;
      acc  <= '0;
    end else if (beat_en) begin
      if (flush_c) begin
        lane <= '0;
        acc  <= '0;
      end else begin
        lane <= lane + LANE_W'(1);
        acc  <= word_data_c;
      end
    end
  end

endmodule

// File: rtl/simple_axis_fifo.sv
// Single-clock upsizing AXI4-Stream FIFO with optional per-frame store-and-forward.
module simple_axis_fifo
  import simple_axis_fifo_pkg::*;
#(
  parameter int unsigned DATA_IN_WIDTH  = DATA_IN_W,
  parameter int unsigned DATA_OUT_WIDTH = DATA_OUT_W,
  parameter int unsigned ADDR_WIDTH     = ADDR_W,
  parameter int unsigned FULL_SLACK     = 1,
  parameter int unsigned FRAME_MODE     = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                      s_axis_tlast,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [DATA_OUT_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);

  localparam int unsigned WORD_DIV  = DATA_OUT_WIDTH / DATA_IN_WIDTH;
  localparam int unsigned MEM_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned P_W       = ADDR_WIDTH + 1;
  localparam int unsigned LIMIT     = MEM_DEPTH - FULL_SLACK;

  logic [P_W-1:0] wr_ptr, rd_ptr, commit_ptr;
  logic [P_W-1:0] count_c, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic           accept_c, wr_en_c, rd_en_c, word_last_c, commit_c;
  logic [DATA_OUT_WIDTH-1:0] word_data_c;
  entry_t         mem [MEM_DEPTH];
  entry_t         rd_entry;

  simple_axis_fifo_packer #(
    .DATA_IN_WIDTH  (DATA_IN_WIDTH),
    .DATA_OUT_WIDTH (DATA_OUT_WIDTH),
    .DIV            (WORD_DIV)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .beat_en     (accept_c),
    .beat_data   (s_axis_tdata),
    .beat_last   (s_axis_tlast),
    .word_en_c   (wr_en_c),
    .word_data_c (word_data_c),
    .word_last_c (word_last_c)
  );

  // Handshakes are decoded from registered pointers only, never from the partner's valid/ready.
  always_comb begin
    count_c       = wr_ptr - rd_ptr;
    s_axis_tready = rst && (count_c < P_W'(LIMIT));
    m_axis_tvalid = rst && (rd_ptr != commit_ptr);
    accept_c      = s_axis_tvalid && s_axis_tready;
    rd_en_c       = m_axis_tvalid && m_axis_tready;
    wr_ptr_nxt    = wr_ptr + P_W'(wr_en_c);
    rd_ptr_nxt    = rd_ptr + P_W'(rd_en_c);
    count_nxt     = wr_ptr_nxt - rd_ptr_nxt;
    // Reaching the fill limit releases an oversize frame so it can stream through.
    commit_c      = (FRAME_MODE == 0) || (wr_en_c && word_last_c) ||
                    (count_nxt == P_W'(LIMIT));
    rd_entry      = mem[rd_ptr[ADDR_WIDTH-1:0]];
    m_axis_tdata  = rst ? rd_entry.data : '0;
    m_axis_tlast  = rst && rd_entry.last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      commit_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      if (commit_c) commit_ptr <= wr_ptr_nxt;
    end
  end

  // Storage carries no reset; pointer state alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_ptr[ADDR_WIDTH-1:0]] <= '{data: word_data_c, last: word_last_c};
  end

endmodule

// File: tb/tb_simple_axis_fifo.sv
// Directed self-checking bench for simple_axis_fifo (frame mode, 16->128, depth 8, slack 1).
module tb_simple_axis_fifo;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [15:0]  s_tdata = '0;
  logic         s_tlast = 1'b0;
  logic         s_tvalid = 1'b0;
  logic         s_tready;
  logic [127:0] m_tdata;
  logic         m_tlast;
  logic         m_tvalid;
  logic         m_tready = 1'b0;

  typedef struct {
    logic [127:0] d;
    logic         l;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          words_read = 0;
  int          frames_read = 0;
  bit          rand_ready = 1'b0;
  logic [15:0] beat_id = '0;
  exp_t        ex;
  logic [127:0] first_word;
  int          w0, f0;

  simple_axis_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: note any read handshake before the edge, score it after.
  task automatic tick();
    logic         rd;
    logic [127:0] d;
    logic         l;
    exp_t         e;
    if (rand_ready) m_tready = ($urandom_range(0, 99) < 80);
    rd = m_tvalid && m_tready;
    d  = m_tdata;
    l  = m_tlast;
    @(posedge clk);
    #1;
    if (rd) begin
      words_read++;
      if (l) frames_read++;
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL extra_word observed=%h expected=none", d);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rd_data", d, e.d);
        chk("rd_last", 128'(l), 128'(e.l));
      end
    end
  endtask

  task automatic send_beat(input logic [15:0] data, input logic last);
    logic acc;
    int   n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = data;
    s_tlast  = last;
    do begin
      acc = s_tready;
      tick();
      n++;
    end while (!acc && n < 300);
    chk("send_accept", 128'(acc), 128'(1));
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic push_exp(input int n, input logic [15:0] base);
    exp_t e;
    int   nw;
    nw = (n + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      e.d = '0;
      for (int k = 0; k < 8; k++)
        if (w * 8 + k < n) e.d[k*16 +: 16] = 16'(base + 16'(w * 8 + k));
      e.l = (w == nw - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) begin
      send_beat(beat_id, i == n - 1);
      beat_id++;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    s_tvalid = 1'b0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_left"}, 128'(exp_q.size()), 128'(0));
    tick();
    tick();
    chk({tag, "_idle"}, 128'(m_tvalid), 128'(0));
  endtask

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_tready", 128'(s_tready), 128'(0));
    chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
    chk("rst_m_tlast",  128'(m_tlast),  128'(0));
    chk("rst_m_tdata",  m_tdata,        128'(0));
    rst = 1'b1;
    #1;
    chk("idle_s_tready", 128'(s_tready), 128'(1));
    chk("idle_m_tvalid", 128'(m_tvalid), 128'(0));

    // 8-beat frame, held until tlast
    m_tready = 1'b1;
    ex.d = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    ex.l = 1'b1;
    exp_q.push_back(ex);
    w0 = words_read;
    for (int i = 0; i < 8; i++) begin
      send_beat(16'(i), i == 7);
      if (i < 7) chk("fm_hold", 128'(m_tvalid), 128'(0));
    end
    chk("fm_valid", 128'(m_tvalid), 128'(1));
    chk("fm_data",  m_tdata, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("fm_last",  128'(m_tlast), 128'(1));
    drain("fm");
    chk("fm_words", 128'(words_read - w0), 128'(1));

    // partial 3-beat frame, upper lanes zero
    ex.d = 128'h0002_0001_0000;
    ex.l = 1'b1;
    exp_q.push_back(ex);
    for (int i = 0; i < 3; i++) send_beat(16'(i), i == 2);
    drain("part");

    // reset mid-frame discards the partial word
    for (int i = 0; i < 3; i++) send_beat(16'hAAAA, 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_rst_s_tready", 128'(s_tready), 128'(0));
    chk("mid_rst_m_tvalid", 128'(m_tvalid), 128'(0));
    chk("mid_rst_m_tdata",  m_tdata,        128'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    beat_id = 16'h0010;
    push_exp(8, beat_id);
    send_frame(8);
    drain("post_rst");

    // back-to-back frames 64..8 beats, random output ready
    rand_ready = 1'b1;
    beat_id = '0;
    w0 = words_read;
    f0 = frames_read;
    for (int f = 0; f < 8; f++) begin
      push_exp(64 - 8 * f, beat_id);
      send_frame(64 - 8 * f);
    end
    drain("b2b");
    chk("b2b_words",  128'(words_read - w0),  128'(36));
    chk("b2b_frames", 128'(frames_read - f0), 128'(8));
    rand_ready = 1'b0;
    m_tready = 1'b1;

    // oversize 512-beat frame releases at count 7
    w0 = words_read;
    f0 = frames_read;
    push_exp(512, beat_id);
    for (int i = 0; i < 512; i++) begin
      send_beat(beat_id, i == 511);
      beat_id++;
      if (i < 55) chk("ovs_hold", 128'(m_tvalid), 128'(0));
      if (i == 55) begin
        chk("ovs_tready_drop", 128'(s_tready), 128'(0));
        chk("ovs_release",     128'(m_tvalid), 128'(1));
      end
    end
    drain("ovs");
    chk("ovs_words",  128'(words_read - w0),  128'(64));
    chk("ovs_frames", 128'(frames_read - f0), 128'(1));

    // backpressure: output stalled for 100 cycles
    m_tready = 1'b0;
    w0 = words_read;
    push_exp(64, beat_id);
    first_word = exp_q[0].d;
    for (int i = 0; i < 56; i++) begin
      send_beat(beat_id, 1'b0);
      beat_id++;
    end
    for (int c = 0; c < 100; c++) begin
      tick();
      chk("bp_s_tready", 128'(s_tready), 128'(0));
      chk("bp_m_tvalid", 128'(m_tvalid), 128'(1));
      chk("bp_m_tdata",  m_tdata, first_word);
    end
    m_tready = 1'b1;
    for (int i = 56; i < 64; i++) begin
      send_beat(beat_id, i == 63);
      beat_id++;
    end
    drain("bp");
    chk("bp_words", 128'(words_read - w0), 128'(8));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simple_axis_fifo.md
# simple_axis_fifo

Single-clock AXI4-Stream FIFO with upsizing width conversion. It packs DATA_IN_WIDTH-bit input beats into DATA_OUT_WIDTH-bit output words and buffers them in a 2**ADDR_WIDTH-entry output-side memory. It sits between a narrow producer (e.g. 16-bit sample or packet source) and a wide consumer (e.g. 128-bit DMA/memory interface). In frame mode, output is held back until a whole frame, or as much of it as fits, is stored.

## Interface
- DATA_IN_WIDTH, 16, input beat width; a multiple of 8.
- DATA_OUT_WIDTH, 128, output word width; DIV = DATA_OUT_WIDTH/DATA_IN_WIDTH must be an integer ≥ 1.
- ADDR_WIDTH, 3, output memory depth DEPTH = 2**ADDR_WIDTH words.
- FULL_SLACK, 1, entries held in reserve before s_axis_tready drops; 0 ≤ FULL_SLACK < DEPTH.
- FRAME_MODE, 1, 1 = store-and-forward per frame; 0 = words visible as soon as written.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  DATA_IN_WIDTH  input beat.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  DATA_OUT_WIDTH  output word.
- m_axis_tlast  out  1  last word of frame.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.

## Operation
- Packer:
  - Accepted beats (tvalid & tready) fill lane k = 0..DIV-1; beat k occupies bits [k*DATA_IN_WIDTH +: DATA_IN_WIDTH]. The first beat of a word is in the LSBs.
  - A word is written to memory when lane DIV-1 is filled or an accepted beat has tlast=1.
  - Unfilled lanes of a tlast word are zero. The stored tlast bit equals the beat's tlast.
  - After a write, the lane counter returns to 0.
- Memory: DEPTH entries of DATA_OUT_WIDTH+1 bits (data plus tlast).
- Pointers: wr_ptr, commit_ptr and rd_ptr are each ADDR_WIDTH+1 bits, with wrap by natural overflow. count = wr_ptr - rd_ptr.
- s_axis_tready = rst high and count < DEPTH - FULL_SLACK.
- Commit, FRAME_MODE=0: commit_ptr follows wr_ptr.
- Commit, FRAME_MODE=1: commit_ptr <= wr_ptr on the write of a tlast word. It also commits when count reaches DEPTH - FULL_SLACK (oversize-frame release), so frames longer than the FIFO stream through without deadlock.
- Output:
  - m_axis_tvalid = (rd_ptr != commit_ptr).
  - m_axis_tdata and m_axis_tlast are the entry at rd_ptr (first-word fall-through).
  - rd_ptr increments on m_axis_tvalid & m_axis_tready.
- Simultaneous write and read in one cycle are both performed; count is unchanged.
- Reset (asynchronous, any time, including mid-frame):
  - All pointers and the lane counter are cleared; any partial word is discarded.
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0 and m_axis_tdata=0 while rst is low.

## Timing
- Input beat accepted on the clock edge where tvalid & tready are both high. The beat on s_axis_tdata may change after that edge.
- FRAME_MODE=0: the word completed at edge N gives m_axis_tvalid high after edge N (visible in cycle N+1).
- FRAME_MODE=1: the first word of a frame becomes valid in the cycle after the tlast word is written, or after the release commit.
- m_axis_tvalid never depends combinationally on m_axis_tready. s_axis_tready does not depend combinationally on s_axis_tvalid.
- Output data is held stable while m_axis_tvalid & !m_axis_tready.
- Throughput: one input beat per clock while not near full. One output word per clock while committed data exists.

## Structure
- Shared package: DIV, DEPTH and the pointer width as localparam-derived constants, plus the stored-entry record type (data, last).
- One sub-module: simple_axis_fifo_packer, the DIV-lane gearbox with lane counter, zero-fill and tlast flush. The parent holds the memory, pointers and commit logic.

## Test plan
- Reset release, idle: after rst goes high, s_axis_tready=1 and m_axis_tvalid=0; outputs are 0 during reset.
- 8-beat frame 0..7 with m_axis_tready=1:
  - Exactly one output word, 0x0007_0006_0005_0004_0003_0002_0001_0000, with tlast=1.
  - FRAME_MODE=1: valid only after the last beat.
- Partial frame of 3 beats (0,1,2, tlast on beat 2): one word 0x…0000_0002_0001_0000 with the upper 80 bits zero, tlast=1.
- Back-to-back frames of 64, 56, 48, 40, 32, 24, 16 and 8 beats, with m_axis_tready random at 80% high:
  - Word counts are 8, 7, 6, 5, 4, 3, 2 and 1.
  - tlast is set only on the final word of each frame.
  - Data matches ascending beat indices; nothing is lost or duplicated.
- Oversize 512-beat frame in FRAME_MODE=1, DEPTH=8, FULL_SLACK=1:
  - s_axis_tready drops at count=7; the release commit occurs and the transfer completes with 64 words and tlast on word 63.
  - No deadlock.
- Backpressure with m_axis_tready=0 for 100 cycles: s_axis_tready falls at count=DEPTH-FULL_SLACK; m_axis_tdata and m_axis_tvalid stay stable; full data is recovered once ready returns.
